stage_ex: RTL and testbench
===========================

STAGE_EX -- requirements
Module: stage_ex

Interface
REQ-001 Clock and reset SHALL be one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  async active-high reset.
REQ-004 en, stall  in  1 each  register update allowed when en=1 and stall=0.
REQ-005 in_flush  in  1  1 = incoming slot is a bubble.
REQ-006 in_reg_wr, in_reg_addr_rd/r1/r2  in  1, REG_ADDR_W x3  decoded destination/sources.
REQ-007 in_alu_op  in  4  {rev, func3}.
REQ-008 in_alu_src_arg1/arg2  in  ALU_SRC_W  ALU_SRC_R or ALU_SRC_IMM.
REQ-009 in_imm  in  DATA_W  sign-extended immediate.
REQ-010 regfile_addr1/2  out  REG_ADDR_W  combinational copy of in_reg_addr_r1/r2.
REQ-011 regfile_data1/2  in  DATA_W  same-cycle regfile read data.
REQ-012 wb_reg_wr, wb_reg_addr, wb_data  in  1, REG_ADDR_W, DATA_W  writeback-stage write this cycle.
REQ-013 out_reg_wr, out_reg_addr_rd, out_result  out  1, REG_ADDR_W, DATA_W  registered result.
REQ-014 out_flush  out  1  registered bubble flag.
REQ-015 out_retire_cnt  out  32  retired-op count.

Function
REQ-016 Operand A SHALL use source r1 (in_alu_src_arg1 is always ALU_SRC_R); operand B SHALL be in_imm when in_alu_src_arg2=ALU_SRC_IMM, else source r2.
REQ-017 Source value for address 0 SHALL be 0.
REQ-018 Nonzero source value priority: (1) out_result when out_reg_wr=1, out_flush=0, out_reg_addr_rd matches; (2) wb_data when wb_reg_wr=1, wb_reg_addr matches; (3) regfile data.
REQ-019 ALU ops: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT signed, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; others result 0.
REQ-020 Shift amount SHALL be B[4:0]; ADD/SUB wrap modulo 2^32; SLT/SLTU yield 32'd1 or 32'd0.
REQ-021 Latency SHALL be one cycle: operands/result computed combinationally, captured at the rising edge when en=1 and stall=0.
REQ-022 On capture: out_reg_wr <= in_reg_wr & ~in_flush; out_flush <= in_flush; out_reg_addr_rd <= in_reg_addr_rd; out_result <= ALU result.
REQ-023 When en=0 or stall=1 every output register SHALL hold, including out_retire_cnt.
REQ-024 Held out_result SHALL still forward per REQ-018 during stall.
REQ-025 A bubble (in_flush=1) SHALL never set out_reg_wr and SHALL not count as retired.
REQ-026 Simultaneous EX and WB match on the same address SHALL select EX (newer).

Reset
REQ-027 While rst=1: out_reg_wr=0, out_reg_addr_rd=0, out_result=0, out_flush=1, out_retire_cnt=0, immediately without clock.
REQ-028 Reset deassertion mid-stream: first capture after rst=0 follows REQ-022 normally; no forwarding from pre-reset state.

Configuration
REQ-029 Macro STAGE_EX_RETIRE_CNT_EN defined: out_retire_cnt increments by 1 on each capture with in_flush=0, wrapping 0xFFFFFFFF -> 0.
REQ-030 Macro undefined: port remains, tied to 0, no counter flops.

Verification
REQ-031 ADD r1=5 (regfile 7), r2=6 (regfile 3), rd=8 -> next cycle out_result=10, out_reg_wr=1, out_reg_addr_rd=8.
REQ-032 Back-to-back: ADDI x1 imm=5 (x0 source), then SUB rd=2 r1=x1 r2=x1 with regfile data 0 -> second result 0 via EX forward, first result 5.
REQ-033 SRA A=0x80000000, B=4 -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF vs 1 -> 1, SLTU -> 0.
REQ-034 stall=1 for 3 cycles with new inputs -> outputs unchanged; in_flush=1 capture -> out_reg_wr=0, out_flush=1, counter unchanged.
REQ-035 Both wb match (wb_data=0x11) and EX match (out_result=0x22) on r1=3 -> operand A = 0x22; rst pulse mid-stream -> outputs per REQ-027 within the same cycle.
REQ-036 With STAGE_EX_RETIRE_CNT_EN: counter preloaded to 0xFFFFFFFF via 2^32-1 captures is impractical -> force-based check: wrap to 0; without macro out_retire_cnt=0 always.

Source files
------------

// File: rtl/stage_ex_if.sv
// Bundle of all execute-stage signals except clk/rst: decoded inputs,
// regfile read port, writeback bypass and the registered EX results.
interface stage_ex_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SRC_W  = 1
);
    logic                  en;
    logic                  stall;
    logic                  in_flush;
    logic                  in_reg_wr;
    logic [REG_ADDR_W-1:0] in_reg_addr_rd;
    logic [REG_ADDR_W-1:0] in_reg_addr_r1;
    logic [REG_ADDR_W-1:0] in_reg_addr_r2;
    logic [3:0]            in_alu_op;
    logic [ALU_SRC_W-1:0]  in_alu_src_arg1;
    logic [ALU_SRC_W-1:0]  in_alu_src_arg2;
    logic [DATA_W-1:0]     in_imm;
    logic [REG_ADDR_W-1:0] regfile_addr1;
    logic [REG_ADDR_W-1:0] regfile_addr2;
    logic [DATA_W-1:0]     regfile_data1;
    logic [DATA_W-1:0]     regfile_data2;
    logic                  wb_reg_wr;
    logic [REG_ADDR_W-1:0] wb_reg_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  out_reg_wr;
    logic [REG_ADDR_W-1:0] out_reg_addr_rd;
    logic [DATA_W-1:0]     out_result;
    logic                  out_flush;
    logic [31:0]           out_retire_cnt;

    modport master (
        output en, stall, in_flush, in_reg_wr, in_reg_addr_rd, in_reg_addr_r1,
               in_reg_addr_r2, in_alu_op, in_alu_src_arg1, in_alu_src_arg2, in_imm,
               regfile_data1, regfile_data2, wb_reg_wr, wb_reg_addr, wb_data,
        input  regfile_addr1, regfile_addr2, out_reg_wr, out_reg_addr_rd,
               out_result, out_flush, out_retire_cnt
    );

    modport slave (
        input  en, stall, in_flush, in_reg_wr, in_reg_addr_rd, in_reg_addr_r1,
               in_reg_addr_r2, in_alu_op, in_alu_src_arg1, in_alu_src_arg2, in_imm,
               regfile_data1, regfile_data2, wb_reg_wr, wb_reg_addr, wb_data,
        output regfile_addr1, regfile_addr2, out_reg_wr, out_reg_addr_rd,
               out_result, out_flush, out_retire_cnt
    );
endinterface

// File: rtl/stage_ex.sv
// Single-cycle execute stage: forwarded operands, ALU, registered result.
// Define STAGE_EX_RETIRE_CNT_EN to build the retired-op counter.
module stage_ex #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SRC_W  = 1
) (
    input  logic      clk,
    input  logic      rst,
    stage_ex_if.slave bus
);
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = ALU_SRC_W'(1);

    // Newest producer wins: EX result, then writeback, then the regfile.
    function automatic logic signed [DATA_W-1:0] pick_src(
        input logic [REG_ADDR_W-1:0]   addr,
        input logic signed [DATA_W-1:0] rf_data,
        input logic                     ex_vld,
        input logic [REG_ADDR_W-1:0]   ex_addr,
        input logic signed [DATA_W-1:0] ex_data,
        input logic                     wb_vld,
        input logic [REG_ADDR_W-1:0]   wb_addr,
        input logic signed [DATA_W-1:0] wb_data
    );
        if (addr == '0)                      return '0;
        else if (ex_vld && ex_addr == addr)  return ex_data;
        else if (wb_vld && wb_addr == addr)  return wb_data;
        else                                 return rf_data;
    endfunction

    function automatic logic signed [DATA_W-1:0] alu(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << shamt;
            4'b0010: return (a < b) ? DATA_W'(1) : '0;
            4'b0011: return ($unsigned(a) < $unsigned(b)) ? DATA_W'(1) : '0;
            4'b0100: return a ^ b;
            4'b0101: return $signed($unsigned(a) >> shamt);
            4'b1101: return a >>> shamt;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return '0;
        endcase
    endfunction

    logic                      out_reg_wr_q, out_reg_wr_d;
    logic                      out_flush_q, out_flush_d;
    logic [REG_ADDR_W-1:0]     out_reg_addr_q, out_reg_addr_d;
    logic signed [DATA_W-1:0]  out_result_q, out_result_d;
    logic                      capture;
    logic                      vld_p1;
    logic signed [DATA_W-1:0]  src1, src2, op_a, op_b, alu_res;
    logic                      unused_src_arg1;

    // Operand A is always a register source.
    assign unused_src_arg1 = ^bus.in_alu_src_arg1;

    assign bus.regfile_addr1 = bus.in_reg_addr_r1;
    assign bus.regfile_addr2 = bus.in_reg_addr_r2;

    assign capture = bus.en & ~bus.stall;
    assign vld_p1  = out_reg_wr_q & ~out_flush_q;

    // ---- stage p0: operand select and ALU (combinational) ----
    always_comb begin
        src1 = pick_src(bus.in_reg_addr_r1, bus.regfile_data1, vld_p1, out_reg_addr_q,
                        out_result_q, bus.wb_reg_wr, bus.wb_reg_addr, bus.wb_data);
        src2 = pick_src(bus.in_reg_addr_r2, bus.regfile_data2, vld_p1, out_reg_addr_q,
                        out_result_q, bus.wb_reg_wr, bus.wb_reg_addr, bus.wb_data);
        op_a    = src1;
        op_b    = (bus.in_alu_src_arg2 == ALU_SRC_IMM) ? $signed(bus.in_imm) : src2;
        alu_res = alu(bus.in_alu_op, op_a, op_b);
    end

    always_comb begin
        out_reg_wr_d   = out_reg_wr_q;
        out_flush_d    = out_flush_q;
        out_reg_addr_d = out_reg_addr_q;
        out_result_d   = out_result_q;
        if (capture) begin
            out_reg_wr_d   = bus.in_reg_wr & ~bus.in_flush;
            out_flush_d    = bus.in_flush;
            out_reg_addr_d = bus.in_reg_addr_rd;
            out_result_d   = alu_res;
        end
    end

    // ---- stage p1: EX output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg_wr_q   <= 1'b0;
            out_flush_q    <= 1'b1;
            out_reg_addr_q <= '0;
            out_result_q   <= '0;
        end else begin
            out_reg_wr_q   <= out_reg_wr_d;
            out_flush_q    <= out_flush_d;
            out_reg_addr_q <= out_reg_addr_d;
            out_result_q   <= out_result_d;
        end
    end

    assign bus.out_reg_wr      = out_reg_wr_q;
    assign bus.out_flush       = out_flush_q;
    assign bus.out_reg_addr_rd = out_reg_addr_q;
    assign bus.out_result      = out_result_q;

`ifdef STAGE_EX_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (capture && !bus.in_flush) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign bus.out_retire_cnt = retire_cnt_q;
`else
    assign bus.out_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: reset, ALU ops, forwarding, stall/flush, counter.
module tb_stage_ex;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [31:0] exp_cnt;

    stage_ex_if #(.DATA_W(32), .REG_ADDR_W(5), .ALU_SRC_W(1)) bus ();

    stage_ex #(.DATA_W(32), .REG_ADDR_W(5), .ALU_SRC_W(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_retire();
`ifdef STAGE_EX_RETIRE_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic imm_sel, input logic [31:0] imm,
                          input logic [31:0] d1, input logic [31:0] d2, input logic wr);
        bus.in_alu_op       = op;
        bus.in_reg_addr_rd  = rd;
        bus.in_reg_addr_r1  = r1;
        bus.in_reg_addr_r2  = r2;
        bus.in_alu_src_arg1 = 1'b0;
        bus.in_alu_src_arg2 = imm_sel;
        bus.in_imm          = imm;
        bus.regfile_data1   = d1;
        bus.regfile_data2   = d2;
        bus.in_reg_wr       = wr;
    endtask

    task automatic tick();
        logic cap;
        cap = bus.en && !bus.stall && !bus.in_flush && !rst;
        @(posedge clk);
        #1;
        if (cap) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        bus.in_reg_addr_r1 = 5'd10;
        bus.in_reg_addr_r2 = 5'd17;
        #1;
        total_cnt++; if (bus.out_reg_wr !== 1'b0) $display("FAIL rst_wr: got %b want 0", bus.out_reg_wr); else pass_cnt++;
        total_cnt++; if (bus.out_reg_addr_rd !== 5'd0) $display("FAIL rst_rd: got %0d want 0", bus.out_reg_addr_rd); else pass_cnt++;
        total_cnt++; if (bus.out_result !== 32'd0) $display("FAIL rst_result: got %h want 0", bus.out_result); else pass_cnt++;
        total_cnt++; if (bus.out_flush !== 1'b1) $display("FAIL rst_flush: got %b want 1", bus.out_flush); else pass_cnt++;
        total_cnt++; if (bus.out_retire_cnt !== 32'd0) $display("FAIL rst_cnt: got %h want 0", bus.out_retire_cnt); else pass_cnt++;
        total_cnt++; if (bus.regfile_addr1 !== 5'd10 || bus.regfile_addr2 !== 5'd17)
            $display("FAIL rf_addr: got %0d/%0d want 10/17", bus.regfile_addr1, bus.regfile_addr2); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_add();
        set_op(4'b0000, 5'd8, 5'd5, 5'd6, 1'b0, 32'd0, 32'd7, 32'd3, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd10) $display("FAIL add_result: got %h want %h", bus.out_result, 32'd10); else pass_cnt++;
        total_cnt++; if (bus.out_reg_wr !== 1'b1 || bus.out_reg_addr_rd !== 5'd8 || bus.out_flush !== 1'b0)
            $display("FAIL add_ctrl: got wr=%b rd=%0d fl=%b want 1/8/0", bus.out_reg_wr, bus.out_reg_addr_rd, bus.out_flush); else pass_cnt++;
        total_cnt++; if (bus.out_retire_cnt !== exp_retire()) $display("FAIL add_cnt: got %h want %h", bus.out_retire_cnt, exp_retire()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // ADDI x1 = x0 + 5; regfile returns junk for x0, which must read as 0
        set_op(4'b0000, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5, 32'h1234, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd5) $display("FAIL b2b_addi: got %h want 5", bus.out_result); else pass_cnt++;
        set_op(4'b1000, 5'd2, 5'd1, 5'd1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd0 || bus.out_reg_addr_rd !== 5'd2)
            $display("FAIL b2b_sub: got %h rd=%0d want 0 rd=2", bus.out_result, bus.out_reg_addr_rd); else pass_cnt++;
        set_op(4'b0000, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        tick();
        set_op(4'b0000, 5'd3, 5'd1, 5'd1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd10) $display("FAIL b2b_add_fwd: got %h want a", bus.out_result); else pass_cnt++;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [14];
        logic [31:0] av  [14];
        logic [31:0] bv  [14];
        logic [31:0] ev  [14];
        ops = '{4'b1101, 4'b0101, 4'b0010, 4'b0011, 4'b0000, 4'b1000, 4'b0001,
                4'b0100, 4'b0110, 4'b0111, 4'b1111, 4'b0011, 4'b0010, 4'b1001};
        av  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1,
                32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h5, 32'h1, 32'h5, 32'h3};
        bv  = '{32'h4, 32'h4, 32'h1, 32'h1, 32'h1, 32'h1, 32'h21,
                32'hFF00FF00, 32'h0F000000, 32'hFF00FF00, 32'h3, 32'hFFFFFFFF, 32'h3, 32'h1};
        ev  = '{32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2,
                32'h0FF00FF0, 32'hFFF0F0F0, 32'hF000F000, 32'h0, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 14; i++) begin
            set_op(ops[i], 5'd9, 5'd10, 5'd0, 1'b1, bv[i], av[i], 32'd0, 1'b1);
            tick();
            total_cnt++; if (bus.out_result !== ev[i])
                $display("FAIL alu_op%0d(%b): got %h want %h", i, ops[i], bus.out_result, ev[i]); else pass_cnt++;
        end
    endtask

    task automatic test_stall_flush();
        set_op(4'b0000, 5'd7, 5'd10, 5'd0, 1'b1, 32'd23, 32'd100, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd123) $display("FAIL stall_pre: got %h want 7b", bus.out_result); else pass_cnt++;
        bus.stall = 1'b1;
        set_op(4'b0000, 5'd12, 5'd7, 5'd0, 1'b1, 32'd1, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (bus.out_result !== 32'd123 || bus.out_reg_addr_rd !== 5'd7 || bus.out_reg_wr !== 1'b1 || bus.out_flush !== 1'b0)
                $display("FAIL stall_hold%0d: got %h rd=%0d wr=%b fl=%b want 7b rd=7 wr=1 fl=0", i,
                         bus.out_result, bus.out_reg_addr_rd, bus.out_reg_wr, bus.out_flush); else pass_cnt++;
        end
        bus.stall = 1'b0;
        bus.en = 1'b0;
        tick();
        total_cnt++; if (bus.out_result !== 32'd123 || bus.out_reg_addr_rd !== 5'd7)
            $display("FAIL en_hold: got %h rd=%0d want 7b rd=7", bus.out_result, bus.out_reg_addr_rd); else pass_cnt++;
        total_cnt++; if (bus.out_retire_cnt !== exp_retire()) $display("FAIL hold_cnt: got %h want %h", bus.out_retire_cnt, exp_retire()); else pass_cnt++;
        bus.en = 1'b1;
        tick();
        total_cnt++; if (bus.out_result !== 32'd124 || bus.out_reg_addr_rd !== 5'd12)
            $display("FAIL stall_release_fwd: got %h rd=%0d want 7c rd=12", bus.out_result, bus.out_reg_addr_rd); else pass_cnt++;
        bus.in_flush = 1'b1;
        set_op(4'b0000, 5'd5, 5'd10, 5'd0, 1'b1, 32'd1, 32'd1, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_reg_wr !== 1'b0 || bus.out_flush !== 1'b1 || bus.out_reg_addr_rd !== 5'd5)
            $display("FAIL flush_ctrl: got wr=%b fl=%b rd=%0d want 0/1/5", bus.out_reg_wr, bus.out_flush, bus.out_reg_addr_rd); else pass_cnt++;
        total_cnt++; if (bus.out_retire_cnt !== exp_retire()) $display("FAIL flush_cnt: got %h want %h", bus.out_retire_cnt, exp_retire()); else pass_cnt++;
        bus.in_flush = 1'b0;
        // flushed slot must not forward: r1=5 reads the regfile
        set_op(4'b0000, 5'd6, 5'd5, 5'd0, 1'b1, 32'd0, 32'd77, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'd77) $display("FAIL flush_nofwd: got %h want 4d", bus.out_result); else pass_cnt++;
    endtask

    task automatic test_priority();
        set_op(4'b0000, 5'd3, 5'd0, 5'd0, 1'b1, 32'h22, 32'd0, 32'd0, 1'b1);
        tick();
        bus.wb_reg_wr   = 1'b1;
        bus.wb_reg_addr = 5'd3;
        bus.wb_data     = 32'h11;
        set_op(4'b0000, 5'd4, 5'd3, 5'd0, 1'b1, 32'd0, 32'h99, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'h22) $display("FAIL prio_ex_over_wb: got %h want 22", bus.out_result); else pass_cnt++;
        set_op(4'b0000, 5'd4, 5'd3, 5'd0, 1'b1, 32'd0, 32'h99, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'h11) $display("FAIL prio_wb: got %h want 11", bus.out_result); else pass_cnt++;
        bus.wb_reg_wr = 1'b0;
        tick();
        total_cnt++; if (bus.out_result !== 32'h99) $display("FAIL prio_rf: got %h want 99", bus.out_result); else pass_cnt++;
        bus.wb_reg_wr   = 1'b1;
        bus.wb_reg_addr = 5'd0;
        bus.wb_data     = 32'h55;
        set_op(4'b0000, 5'd4, 5'd0, 5'd0, 1'b0, 32'd0, 32'h99, 32'h99, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'h0) $display("FAIL x0_zero: got %h want 0", bus.out_result); else pass_cnt++;
        bus.wb_reg_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_op(4'b0000, 5'd3, 5'd0, 5'd0, 1'b1, 32'h77, 32'd0, 32'd0, 1'b1);
        tick();
        rst = 1'b1;
        #2;
        total_cnt++; if (bus.out_reg_wr !== 1'b0 || bus.out_reg_addr_rd !== 5'd0 || bus.out_result !== 32'd0 ||
                         bus.out_flush !== 1'b1 || bus.out_retire_cnt !== 32'd0)
            $display("FAIL midrst: got wr=%b rd=%0d res=%h fl=%b cnt=%h want 0/0/0/1/0", bus.out_reg_wr,
                     bus.out_reg_addr_rd, bus.out_result, bus.out_flush, bus.out_retire_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 32'd0;
        set_op(4'b0000, 5'd6, 5'd3, 5'd0, 1'b1, 32'd0, 32'h40, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_result !== 32'h40 || bus.out_reg_wr !== 1'b1 || bus.out_flush !== 1'b0)
            $display("FAIL post_rst: got %h wr=%b fl=%b want 40/1/0", bus.out_result, bus.out_reg_wr, bus.out_flush); else pass_cnt++;
        total_cnt++; if (bus.out_retire_cnt !== exp_retire()) $display("FAIL post_rst_cnt: got %h want %h", bus.out_retire_cnt, exp_retire()); else pass_cnt++;
    endtask

    task automatic test_retire_cnt();
`ifdef STAGE_EX_RETIRE_CNT_EN
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1 release dut.retire_cnt_q;
        exp_cnt = 32'hFFFFFFFF;
`endif
        set_op(4'b0000, 5'd6, 5'd10, 5'd0, 1'b1, 32'd1, 32'd1, 32'd0, 1'b1);
        tick();
        total_cnt++; if (bus.out_retire_cnt !== exp_retire()) $display("FAIL cnt_wrap: got %h want %h", bus.out_retire_cnt, exp_retire()); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_cnt   = 32'd0;
        bus.en = 1'b1; bus.stall = 1'b0; bus.in_flush = 1'b0;
        bus.wb_reg_wr = 1'b0; bus.wb_reg_addr = 5'd0; bus.wb_data = 32'd0;
        set_op(4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_add();
        test_back_to_back();
        test_alu_ops();
        test_stall_flush();
        test_priority();
        test_reset_mid();
        test_retire_cnt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
